div_issue_ctrl: RTL and testbench

//  Sits directly upstream of the iterative divider core in the ALU back end.

---
 rtl/div_issue_ctrl.sv | 79 +++++++
 tb/tb_div_issue_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues signed/unsigned DIV/MOD to an iterative core, handles bypass cases, sign fix-up and flush
module div_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic             req_rem,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             div_start,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_z,
  input  logic [WIDTH-1:0] div_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             stall
);
  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, BYPASS, DONE, DRAIN} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_nxt;
  logic sx, sy, rem;
  logic accept, x_neg, y_neg, y_zero, ovf;
  logic [WIDTH-1:0] q_fix, r_fix, byp_res;
  assign accept  = req_valid && req_ready && !flush;
  assign x_neg   = req_signed && req_x[WIDTH-1];
  assign y_neg   = req_signed && req_y[WIDTH-1];
  assign y_zero  = req_y == '0;
  assign ovf     = req_signed && req_x == MIN && req_y == '1;
  assign q_fix   = (sx ^ sy) ? -div_z : div_z;
  assign r_fix   = sx ? -div_r : div_r;
  assign byp_res = y_zero ? (req_rem ? req_x : '1) : (req_rem ? '0 : MIN);
  always_comb begin
    state_nxt = state;
    req_ready = state == IDLE && !div_busy;
    div_start = state == START;
    res_valid = state == DONE;
    stall     = state != IDLE && state != DRAIN;
    case (state)
      IDLE:    state_nxt = accept ? ((y_zero || ovf) ? BYPASS : START) : IDLE;
      START:   state_nxt = flush ? DRAIN : WAIT_HI;
      WAIT_HI: state_nxt = flush ? DRAIN : (div_busy ? WAIT_LO : WAIT_HI);
      WAIT_LO: state_nxt = flush ? DRAIN : (div_busy ? WAIT_LO : DONE);
      BYPASS:  state_nxt = flush ? IDLE : DONE;
      DONE:    state_nxt = (flush || res_ready) ? IDLE : DONE;
      DRAIN:   state_nxt = div_busy ? DRAIN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // bypass result is staged at accept; the core path overwrites it when the core finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_x    <= '0;
      div_y    <= '0;
      res_data <= '0;
      sx       <= 1'b0;
      sy       <= 1'b0;
      rem      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        div_x    <= x_neg ? -req_x : req_x;
        div_y    <= y_neg ? -req_y : req_y;
        sx       <= x_neg;
        sy       <= y_neg;
        rem      <= req_rem;
        res_data <= byp_res;
      end
      if (state == WAIT_LO && !div_busy && !flush) res_data <= rem ? r_fix : q_fix;
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: table-driven vectors against a behavioural divider core, plus flush/hold/reset sequences
module tb_div_issue_ctrl;
  logic clk = 1'b0;
  logic rst, flush, req_valid, req_ready, req_signed, req_rem;
  logic [31:0] req_x, req_y, div_x, div_y, div_z, div_r, res_data;
  logic div_start, div_busy, res_valid, res_ready, stall;
  logic core_busy, stale;
  logic [31:0] cx, cy;
  int lat = 3;
  int cnt = 0;
  int starts = 0;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic s; logic rem; logic [31:0] x; logic [31:0] y; logic byp; int lat;
    logic [31:0] dx; logic [31:0] dy; logic [31:0] res;
  } vec_t;
  vec_t vt[15];

  div_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_signed(req_signed), .req_rem(req_rem), .req_x(req_x), .req_y(req_y),
    .div_start(div_start), .div_x(div_x), .div_y(div_y), .div_busy(div_busy),
    .div_z(div_z), .div_r(div_r), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .stall(stall)
  );

  always #5 clk = ~clk;
  assign div_busy = core_busy | stale;

  // core model: busy for lat cycles starting the cycle after the start pulse
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_busy <= 1'b0;
      cnt <= 0;
      div_z <= '0;
      div_r <= '0;
    end else if (div_start) begin
      core_busy <= 1'b1;
      cnt <= lat;
      div_z <= (div_y == 0) ? '1 : div_x / div_y;
      div_r <= (div_y == 0) ? div_x : div_x % div_y;
      cx <= div_x;
      cy <= div_y;
      starts <= starts + 1;
    end else if (core_busy) begin
      if (cnt <= 1) core_busy <= 1'b0;
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input int hold);
    int s0, n;
    logic [31:0] held;
    @(negedge clk);
    req_valid = 1'b1; req_signed = v.s; req_rem = v.rem; req_x = v.x; req_y = v.y; lat = v.lat;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    s0 = starts;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 40);
    chk("latency", n, v.byp ? 32'd2 : 32'(3 + v.lat));
    chk("start_pulses", starts - s0, v.byp ? 32'd0 : 32'd1);
    if (!v.byp) begin
      chk("div_x", cx, v.dx);
      chk("div_y", cy, v.dy);
    end
    chk("res_data", res_data, v.res);
    chk("stall_busy", {31'd0, stall}, 32'd1);
    held = res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_data", res_data, held);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("res_valid_clr", {31'd0, res_valid}, 32'd0);
    chk("ready_after_hs", {31'd0, req_ready}, 32'd1);
    chk("stall_clr", {31'd0, stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, n;
    logic seen;
    vt[0]  = '{1'b1, 1'b0, 32'd100,       32'hFFFFFFF9, 1'b0, 3, 32'd100,       32'd7,        32'hFFFFFFF2};
    vt[1]  = '{1'b1, 1'b1, 32'hFFFFFF9C,  32'd7,        1'b0, 4, 32'd100,       32'd7,        32'hFFFFFFFE};
    vt[2]  = '{1'b1, 1'b0, 32'hFFFFFF9C,  32'd7,        1'b0, 2, 32'd100,       32'd7,        32'hFFFFFFF2};
    vt[3]  = '{1'b0, 1'b0, 32'hFFFFFFFF,  32'd0,        1'b1, 0, 32'd0,         32'd0,        32'hFFFFFFFF};
    vt[4]  = '{1'b0, 1'b1, 32'hFFFFFFFF,  32'd0,        1'b1, 0, 32'd0,         32'd0,        32'hFFFFFFFF};
    vt[5]  = '{1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF, 1'b1, 0, 32'd0,         32'd0,        32'h80000000};
    vt[6]  = '{1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF, 1'b1, 0, 32'd0,         32'd0,        32'd0};
    vt[7]  = '{1'b0, 1'b0, 32'hFFFFFFF9,  32'd7,        1'b0, 1, 32'hFFFFFFF9,  32'd7,        32'h24924923};
    vt[8]  = '{1'b0, 1'b1, 32'hFFFFFFF9,  32'd7,        1'b0, 5, 32'hFFFFFFF9,  32'd7,        32'd4};
    vt[9]  = '{1'b1, 1'b0, 32'hFFFFFF9C,  32'hFFFFFFF9, 1'b0, 3, 32'd100,       32'd7,        32'd14};
    vt[10] = '{1'b1, 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 1'b0, 3, 32'd100,       32'd7,        32'hFFFFFFFE};
    vt[11] = '{1'b1, 1'b0, 32'h80000000,  32'd2,        1'b0, 2, 32'h80000000,  32'd2,        32'hC0000000};
    vt[12] = '{1'b1, 1'b1, 32'd7,         32'd0,        1'b1, 0, 32'd0,         32'd0,        32'd7};
    vt[13] = '{1'b0, 1'b0, 32'h80000000,  32'hFFFFFFFF, 1'b0, 2, 32'h80000000,  32'hFFFFFFFF, 32'd0};
    vt[14] = '{1'b1, 1'b1, 32'd100,       32'hFFFFFFF9, 1'b0, 1, 32'd100,       32'd7,        32'd2};
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_signed = 1'b0; req_rem = 1'b0;
    req_x = '0; req_y = '0; res_ready = 1'b0; stale = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_div_start", {31'd0, div_start}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_div_x", div_x, 32'd0);
    chk("rst_div_y", div_y, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) do_op(vt[i], i == 0 ? 5 : 0);

    // flush two cycles after the start pulse, then a fresh request
    @(negedge clk);
    lat = 6; req_valid = 1'b1; req_signed = 1'b0; req_rem = 1'b0; req_x = 32'd50; req_y = 32'd5;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("flush_start_pulse", {31'd0, div_start}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_ready_low", {31'd0, req_ready}, 32'd0);
    seen = 1'b0; n = 0;
    do begin
      if (res_valid) seen = 1'b1;
      @(negedge clk); n++;
    end while (!req_ready && n < 30);
    chk("drain_no_result", {31'd0, seen}, 32'd0);
    chk("drain_exit", {31'd0, req_ready}, 32'd1);
    chk("drain_busy_low", {31'd0, div_busy}, 32'd0);
    do_op('{1'b0, 1'b0, 32'd9, 32'd3, 1'b0, 3, 32'd9, 32'd3, 32'd3}, 0);

    // flush and req_valid together: nothing accepted
    @(negedge clk);
    s0 = starts;
    req_valid = 1'b1; flush = 1'b1; req_x = 32'd9; req_y = 32'd3;
    @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_wins_stall", {31'd0, stall}, 32'd0);
    chk("flush_wins_starts", starts - s0, 32'd0);

    // flush in DONE drops the result without a handshake
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b1; req_rem = 1'b0; req_x = 32'd7; req_y = 32'd0;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_valid", {31'd0, res_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("done_flush_valid", {31'd0, res_valid}, 32'd0);
    chk("done_flush_ready", {31'd0, req_ready}, 32'd1);

    // stale busy while idle blocks acceptance
    @(negedge clk);
    stale = 1'b1; req_valid = 1'b1; req_x = 32'd9; req_y = 32'd3;
    #1 chk("stale_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("stale_no_accept", {31'd0, stall}, 32'd0);
    req_valid = 1'b0; stale = 1'b0;
    #1 chk("stale_release", {31'd0, req_ready}, 32'd1);

    // async reset while waiting on the core
    @(negedge clk);
    lat = 8; req_valid = 1'b1; req_signed = 1'b0; req_x = 32'd100; req_y = 32'd7;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", {31'd0, stall}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_div_x", div_x, 32'd0);
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op('{1'b1, 1'b0, 32'd100, 32'hFFFFFFF9, 1'b0, 2, 32'd100, 32'd7, 32'hFFFFFFF2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
